encoder_turn_tracker: RTL and testbench
=======================================

Name: encoder_turn_tracker

Overview:
- Sits directly downstream of the SPI absolute-encoder reader. Consumes its 19-bit single-turn position and data_valid strobe.
- Unwraps the single-turn value across the 0/2^19 boundary into a signed multi-turn position, with software zeroing.
- Rejects glitch samples and flags a stalled SPI link.
- Optionally reports per-sample velocity and sample period for the MicroBlaze control loop.

Parameters:
- POS_W, 19: single-turn position width (bits).
- TURN_W, 13: signed turn-counter width.
- MAX_STEP, 4096: largest accepted |wrapped delta| between consecutive samples, in counts.
- REJECT_LIMIT, 3: consecutive rejected samples after which the next sample is force-accepted.
- TIMEOUT, 1000000: clk cycles without an accepted sample before the stale fault sets.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- enable, in, 1: tracker enable; low forces UNPRIMED.
- sample_val, in, POS_W: raw single-turn position from the SPI reader.
- sample_valid, in, 1: one-cycle strobe, sample_val valid.
- zero_req, in, 1: one-cycle pulse, define current position as zero.
- pos_out, out, POS_W+TURN_W: signed multi-turn position.
- pos_valid, out, 1: one-cycle pulse, pos_out updated.
- turn_count, out, TURN_W: signed turn counter.
- primed, out, 1: at least one sample accepted since prime.
- fault_glitch, out, 1: last sample rejected.
- fault_stale, out, 1: timeout expired.
- velocity, out, POS_W: signed counts per sample.
- period, out, 24: clk cycles between the last two accepted samples.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state UNPRIMED; internal last_raw=0, offset=0, reject_cnt=0, stale_cnt=0.
- States: UNPRIMED, TRACK, STALE.
- UNPRIMED, first sample_valid with enable=1:
  - last_raw=sample_val, turn=0, offset=sample_val only if no zero has been requested (else offset retained), primed=1.
  - Go to TRACK.
- TRACK, each sample_valid:
  - Stage 1: d = sample_val - last_raw, computed mod 2^POS_W and interpreted signed (range -2^(POS_W-1)..2^(POS_W-1)-1).
  - Wrap: sample_val < last_raw with raw difference > 2^(POS_W-1) gives turn+1. sample_val > last_raw with difference > 2^(POS_W-1) gives turn-1.
  - Glitch: |d| > MAX_STEP means the sample is rejected. Set fault_glitch=1, reject_cnt+1, no pos_valid, last_raw and turn unchanged.
  - Force-accept: when reject_cnt reaches REJECT_LIMIT, the next sample is accepted without the glitch check and turn is unchanged (re-sync).
  - On accept: fault_glitch=0, reject_cnt=0, stale_cnt=0, last_raw=sample_val.
  - Stage 2: pos_out = {turn, sample_val} - offset, modulo 2^(POS_W+TURN_W). pos_valid pulses.
- Latency: pos_valid is asserted exactly 2 cycles after the accepting sample_valid edge. The tracker accepts a new sample every cycle (fully pipelined).
- Turn wrap: turn_count wraps two's complement at the TURN_W limits; pos_out wraps consistently with it.
- Stale detection:
  - stale_cnt increments every cycle in TRACK and saturates.
  - When stale_cnt reaches TIMEOUT: go to STALE, fault_stale=1.
  - In STALE, the next sample is accepted with no glitch check and no wrap detection (turns may be lost; turn is preserved). fault_stale clears, return to TRACK, pos_valid pulses.
- zero_req:
  - Sets offset={0,last_raw} and turn=0, so the next pos_out reads 0.
  - Simultaneous with sample_valid: the sample is processed first, then the zero applies to the new raw; the pos_out emitted for that sample is 0.
  - In UNPRIMED: the request is latched and applied at the first sample.
- enable=0:
  - Samples are ignored; state goes to UNPRIMED; primed=0; faults clear.
  - pos_out, turn_count and velocity hold.
  - A pos_valid already in the pipeline still issues.
- Reset mid-pipeline: everything returns to reset values asynchronously; no pos_valid is issued.

Optional Feature:
- Macro: ENC_VELOCITY_EN.
- Defined:
  - velocity = wrapped d of each accepted sample, registered with pos_valid.
  - period = cycles between the last two accepted samples, saturating at 2^24-1.
  - Force-accepted and STALE-recovery samples set velocity=0 and period=0.
- Undefined: velocity and period are tied to 0; the delta and period registers are not synthesized.

Test Plan:
- Reset, enable=1, sample 1000 -> primed=1, pos_valid 2 cycles later, pos_out=0; samples 1000 then 1100 -> pos_out=100, velocity=100.
- Wrap forward: samples 524200 -> 100 -> turn_count=1, pos_out=(524288+100)-524200=188; wrap reverse: 100 -> 524200 -> turn back to 0.
- Glitch: after 5000, sample 20000 -> fault_glitch=1, no pos_valid; three more samples of 20000 -> fourth one force-accepted, fault_glitch=0, velocity=0.
- Stale: TIMEOUT=100, no samples for 100 cycles -> fault_stale=1; next sample -> fault_stale=0, pos_valid, turn preserved.
- zero_req coincident with sample 3000 (turn 2) -> pos_out=0, turn_count=0; next sample 3050 -> pos_out=50.
- enable deassert between samples -> primed=0, outputs held; reassert plus sample 700 -> re-primes, pos_out relative to existing offset; rst_n pulse mid-pipeline -> no pos_valid, all outputs 0.

Source files
------------

// File: rtl/encoder_turn_tracker.sv
// Multi-turn unwrapper for the SPI absolute encoder: glitch reject, stale link, zeroing.
// Define ENC_VELOCITY_EN to add per-sample velocity and sample-period outputs.
module encoder_turn_tracker #(
    parameter int POS_W        = 19,
    parameter int TURN_W       = 13,
    parameter int MAX_STEP     = 4096,
    parameter int REJECT_LIMIT = 3,
    parameter int TIMEOUT      = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [POS_W-1:0]          sample_val,
    input  logic                      sample_valid,
    input  logic                      zero_req,
    output logic [POS_W+TURN_W-1:0]   pos_out,
    output logic                      pos_valid,
    output logic [TURN_W-1:0]         turn_count,
    output logic                      primed,
    output logic                      fault_glitch,
    output logic                      fault_stale,
    output logic [POS_W-1:0]          velocity,
    output logic [23:0]               period
);

    localparam int FULL_W = POS_W + TURN_W;
    localparam int RC_W   = $clog2(REJECT_LIMIT + 1);
    localparam int SC_W   = $clog2(TIMEOUT + 1);

    localparam logic [POS_W-1:0]  HALF     = POS_W'(1) << (POS_W - 1);
    localparam logic [POS_W-1:0]  STEP_LIM = POS_W'(MAX_STEP);
    localparam logic [POS_W-1:0]  P_ONE    = POS_W'(1);
    localparam logic [TURN_W-1:0] T_ONE    = TURN_W'(1);
    localparam logic [TURN_W-1:0] T_ZERO   = '0;
    localparam logic [RC_W-1:0]   R_LIM    = RC_W'(REJECT_LIMIT);
    localparam logic [RC_W-1:0]   R_ONE    = RC_W'(1);
    localparam logic [SC_W-1:0]   S_LIM    = SC_W'(TIMEOUT);
    localparam logic [SC_W-1:0]   S_ONE    = SC_W'(1);

    typedef enum logic [1:0] {
        UNPRIMED,
        TRACK,
        STALE
    } state_t;

    state_t              state;
    logic                r_valid;
    logic [POS_W-1:0]    r_val;
    logic                r_zero;
    logic [POS_W-1:0]    last_raw;
    logic [TURN_W-1:0]   turn;
    logic [FULL_W-1:0]   offset;
    logic [RC_W-1:0]     reject_cnt;
    logic [SC_W-1:0]     stale_cnt;
    logic                zero_pend;
    logic                zeroed;
    logic                s1_valid;
    logic [FULL_W-1:0]   s1_cat;
    logic [FULL_W-1:0]   s1_off;

    logic [POS_W-1:0]    d;
    logic [POS_W-1:0]    d_abs;
    logic [POS_W-1:0]    fwd_gap;
    logic                wrap_fwd;
    logic                wrap_rev;
    logic                glitch;
    logic                force_acc;
    logic                normal;
    logic                acc;
    logic [TURN_W-1:0]   turn_nxt;

    // Wrapped delta of the registered sample against the last accepted raw value
    assign d        = r_val - last_raw;
    assign d_abs    = d[POS_W-1] ? (~d + P_ONE) : d;
    assign fwd_gap  = last_raw - r_val;
    assign wrap_fwd = (r_val < last_raw) && (fwd_gap > HALF);
    assign wrap_rev = (r_val > last_raw) && (d > HALF);
    assign glitch   = d_abs > STEP_LIM;
    assign force_acc = reject_cnt >= R_LIM;

    assign normal = r_valid && (state == TRACK) && !force_acc && !glitch;
    assign acc    = r_valid && ((state != TRACK) || force_acc || !glitch);

    assign turn_nxt = (normal && wrap_fwd) ? turn + T_ONE :
                      (normal && wrap_rev) ? turn - T_ONE : turn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_val        <= '0;
            r_zero       <= 1'b0;
            state        <= UNPRIMED;
            last_raw     <= '0;
            turn         <= '0;
            offset       <= '0;
            reject_cnt   <= '0;
            stale_cnt    <= '0;
            zero_pend    <= 1'b0;
            zeroed       <= 1'b0;
            primed       <= 1'b0;
            fault_glitch <= 1'b0;
            fault_stale  <= 1'b0;
            s1_valid     <= 1'b0;
            s1_cat       <= '0;
            s1_off       <= '0;
        end else begin
            r_valid  <= sample_valid && enable;
            r_val    <= sample_val;
            r_zero   <= zero_req;
            s1_valid <= acc;
            if (r_zero) zeroed <= 1'b1;

            if (acc) begin
                state        <= TRACK;
                primed       <= 1'b1;
                fault_glitch <= 1'b0;
                fault_stale  <= 1'b0;
                reject_cnt   <= '0;
                stale_cnt    <= '0;
                last_raw     <= r_val;
                // A coincident zero lands on the new raw value, so this sample reads 0
                if (r_zero || (state == UNPRIMED && zero_pend)) begin
                    turn      <= T_ZERO;
                    offset    <= {T_ZERO, r_val};
                    s1_cat    <= {T_ZERO, r_val};
                    s1_off    <= {T_ZERO, r_val};
                    zero_pend <= 1'b0;
                end else if (state == UNPRIMED) begin
                    turn   <= T_ZERO;
                    s1_cat <= {T_ZERO, r_val};
                    if (zeroed) begin
                        s1_off <= offset;
                    end else begin
                        offset <= {T_ZERO, r_val};
                        s1_off <= {T_ZERO, r_val};
                    end
                end else begin
                    turn   <= turn_nxt;
                    s1_cat <= {turn_nxt, r_val};
                    s1_off <= offset;
                end
            end else begin
                unique case (state)
                    UNPRIMED: begin
                        if (r_zero) zero_pend <= 1'b1;
                    end
                    TRACK: begin
                        if (r_valid) begin
                            fault_glitch <= 1'b1;
                            reject_cnt   <= reject_cnt + R_ONE;
                        end
                        if (stale_cnt >= S_LIM - S_ONE) begin
                            state       <= STALE;
                            fault_stale <= 1'b1;
                            stale_cnt   <= S_LIM;
                        end else begin
                            stale_cnt <= stale_cnt + S_ONE;
                        end
                    end
                    default: ;
                endcase
                if (r_zero && state != UNPRIMED) begin
                    turn   <= T_ZERO;
                    offset <= {T_ZERO, last_raw};
                end
            end

            // Disable wins over any state update; an in-flight s1 result still issues
            if (!enable) begin
                state        <= UNPRIMED;
                primed       <= 1'b0;
                fault_glitch <= 1'b0;
                fault_stale  <= 1'b0;
                reject_cnt   <= '0;
                stale_cnt    <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_valid  <= 1'b0;
            pos_out    <= '0;
            turn_count <= '0;
        end else begin
            pos_valid <= s1_valid;
            if (s1_valid) begin
                pos_out    <= s1_cat - s1_off;
                turn_count <= s1_cat[FULL_W-1:POS_W];
            end
        end
    end

`ifdef ENC_VELOCITY_EN
    localparam logic [23:0] PER_MAX = '1;

    logic [23:0]      per_cnt;
    logic [23:0]      s1_per;
    logic [POS_W-1:0] s1_vel;

    // per_cnt holds cycles elapsed since the previous accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt  <= '0;
            s1_per   <= '0;
            s1_vel   <= '0;
            velocity <= '0;
            period   <= '0;
        end else begin
            if (acc) begin
                per_cnt <= 24'd1;
            end else if (per_cnt != PER_MAX) begin
                per_cnt <= per_cnt + 24'd1;
            end
            if (acc) begin
                s1_vel <= normal ? d : '0;
                s1_per <= normal ? per_cnt : '0;
            end
            if (s1_valid) begin
                velocity <= s1_vel;
                period   <= s1_per;
            end
        end
    end
`else
    assign velocity = '0;
    assign period   = '0;
`endif

endmodule

// File: tb/tb_encoder_turn_tracker.sv
// Directed bench for encoder_turn_tracker with a short stale timeout.
// Velocity/period expectations follow whether ENC_VELOCITY_EN is defined.
module tb_encoder_turn_tracker;

`ifdef ENC_VELOCITY_EN
    localparam bit VEL = 1'b1;
`else
    localparam bit VEL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [18:0] sample_val = '0;
    logic        sample_valid = 1'b0;
    logic        zero_req = 1'b0;
    logic [31:0] pos_out;
    logic        pos_valid;
    logic [12:0] turn_count;
    logic        primed;
    logic        fault_glitch;
    logic        fault_stale;
    logic [18:0] velocity;
    logic [23:0] period;

    int n_cmp = 0;
    int n_bad = 0;
    int pv_cnt = 0;
    int base;

    encoder_turn_tracker #(.TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .sample_val(sample_val), .sample_valid(sample_valid),
        .zero_req(zero_req), .pos_out(pos_out), .pos_valid(pos_valid),
        .turn_count(turn_count), .primed(primed),
        .fault_glitch(fault_glitch), .fault_stale(fault_stale),
        .velocity(velocity), .period(period)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (pos_valid === 1'b1) pv_cnt++;
    end

    task automatic do_reset();
        enable = 1'b0;
        sample_valid = 1'b0;
        zero_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Presents one sample for one cycle; returns on the following negedge
    task automatic drive(input logic [18:0] v, input logic z);
        sample_val = v;
        sample_valid = 1'b1;
        zero_req = z;
        @(negedge clk);
        sample_valid = 1'b0;
        zero_req = 1'b0;
    endtask

    // Drive then wait until the result is visible at the output
    task automatic send(input logic [18:0] v, input logic z);
        drive(v, z);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (pos_out !== 32'd0 || pos_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pos: got %0d/%0b want 0/0", pos_out, pos_valid);
        end
        n_cmp++;
        if (primed !== 1'b0 || turn_count !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_state: got primed=%0b turn=%0d want 0/0", primed, turn_count);
        end
        n_cmp++;
        if (fault_glitch !== 1'b0 || fault_stale !== 1'b0 ||
            velocity !== 19'd0 || period !== 24'd0) begin
            n_bad++;
            $display("FAIL reset_misc: got g=%0b s=%0b v=%0d p=%0d want 0", fault_glitch, fault_stale, velocity, period);
        end
    endtask

    task automatic test_prime();
        do_reset();
        enable = 1'b1;
        drive(19'd1000, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (pos_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL prime_early: got pos_valid=%0b want 0", pos_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (pos_valid !== 1'b1 || pos_out !== 32'd0 || primed !== 1'b1) begin
            n_bad++;
            $display("FAIL prime_out: got v=%0b pos=%0d pr=%0b want 1/0/1", pos_valid, pos_out, primed);
        end
        @(negedge clk);
        n_cmp++;
        if (pos_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL prime_pulse: got pos_valid=%0b want 0", pos_valid);
        end
        send(19'd1100, 1'b0);
        n_cmp++;
        if (pos_valid !== 1'b1 || pos_out !== 32'd100) begin
            n_bad++;
            $display("FAIL step_pos: got v=%0b pos=%0d want 1/100", pos_valid, pos_out);
        end
        n_cmp++;
        if (velocity !== (VEL ? 19'd100 : 19'd0) || period !== (VEL ? 24'd4 : 24'd0)) begin
            n_bad++;
            $display("FAIL step_vel: got v=%0d p=%0d want %0d/%0d", velocity, period, VEL ? 100 : 0, VEL ? 4 : 0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        enable = 1'b1;
        send(19'd524200, 1'b0);
        send(19'd100, 1'b0);
        n_cmp++;
        if (turn_count !== 13'd1 || pos_out !== 32'd188) begin
            n_bad++;
            $display("FAIL wrap_fwd: got turn=%0d pos=%0d want 1/188", turn_count, pos_out);
        end
        n_cmp++;
        if (velocity !== (VEL ? 19'd188 : 19'd0)) begin
            n_bad++;
            $display("FAIL wrap_fwd_vel: got %0d want %0d", velocity, VEL ? 188 : 0);
        end
        send(19'd524200, 1'b0);
        n_cmp++;
        if (turn_count !== 13'd0 || pos_out !== 32'd0) begin
            n_bad++;
            $display("FAIL wrap_rev: got turn=%0d pos=%0d want 0/0", turn_count, pos_out);
        end
        n_cmp++;
        if (velocity !== (VEL ? 19'd524100 : 19'd0)) begin
            n_bad++;
            $display("FAIL wrap_rev_vel: got %0d want %0d", velocity, VEL ? 524100 : 0);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        enable = 1'b1;
        send(19'd5000, 1'b0);
        base = pv_cnt;
        send(19'd20000, 1'b0);
        n_cmp++;
        if (fault_glitch !== 1'b1 || pos_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_rej: got g=%0b v=%0b want 1/0", fault_glitch, pos_valid);
        end
        send(19'd20000, 1'b0);
        send(19'd20000, 1'b0);
        n_cmp++;
        if (pv_cnt - base !== 0 || fault_glitch !== 1'b1 || pos_out !== 32'd0) begin
            n_bad++;
            $display("FAIL glitch_hold: got pulses=%0d g=%0b pos=%0d want 0/1/0", pv_cnt - base, fault_glitch, pos_out);
        end
        send(19'd20000, 1'b0);
        n_cmp++;
        if (pos_valid !== 1'b1 || fault_glitch !== 1'b0 || pos_out !== 32'd15000) begin
            n_bad++;
            $display("FAIL glitch_force: got v=%0b g=%0b pos=%0d want 1/0/15000", pos_valid, fault_glitch, pos_out);
        end
        n_cmp++;
        if (velocity !== 19'd0 || period !== 24'd0 || turn_count !== 13'd0) begin
            n_bad++;
            $display("FAIL glitch_force_vel: got v=%0d p=%0d t=%0d want 0/0/0", velocity, period, turn_count);
        end
    endtask

    task automatic test_stale();
        do_reset();
        enable = 1'b1;
        send(19'd524200, 1'b0);
        send(19'd100, 1'b0);
        repeat (90) @(negedge clk);
        n_cmp++;
        if (fault_stale !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_early: got %0b want 0", fault_stale);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (fault_stale !== 1'b1 || primed !== 1'b1) begin
            n_bad++;
            $display("FAIL stale_set: got s=%0b pr=%0b want 1/1", fault_stale, primed);
        end
        send(19'd300000, 1'b0);
        n_cmp++;
        if (fault_stale !== 1'b0 || pos_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stale_clr: got s=%0b v=%0b want 0/1", fault_stale, pos_valid);
        end
        n_cmp++;
        if (turn_count !== 13'd1 || pos_out !== 32'd300088 || velocity !== 19'd0) begin
            n_bad++;
            $display("FAIL stale_pos: got t=%0d pos=%0d v=%0d want 1/300088/0", turn_count, pos_out, velocity);
        end
    endtask

    task automatic test_zero();
        do_reset();
        enable = 1'b1;
        send(19'd524200, 1'b0);
        send(19'd100, 1'b0);
        for (int i = 0; i < 4; i++) send(19'd520000, 1'b0);
        send(19'd524000, 1'b0);
        send(19'd100, 1'b0);
        n_cmp++;
        if (turn_count !== 13'd2 || pos_out !== 32'd524476) begin
            n_bad++;
            $display("FAIL zero_pre: got t=%0d pos=%0d want 2/524476", turn_count, pos_out);
        end
        send(19'd3000, 1'b1);
        n_cmp++;
        if (pos_valid !== 1'b1 || pos_out !== 32'd0 || turn_count !== 13'd0) begin
            n_bad++;
            $display("FAIL zero_hit: got v=%0b pos=%0d t=%0d want 1/0/0", pos_valid, pos_out, turn_count);
        end
        send(19'd3050, 1'b0);
        n_cmp++;
        if (pos_out !== 32'd50 || velocity !== (VEL ? 19'd50 : 19'd0)) begin
            n_bad++;
            $display("FAIL zero_next: got pos=%0d v=%0d want 50/%0d", pos_out, velocity, VEL ? 50 : 0);
        end
    endtask

    // Continues from test_zero: offset is {0,3000}
    task automatic test_enable();
        send(19'd20000, 1'b0);
        n_cmp++;
        if (fault_glitch !== 1'b1) begin
            n_bad++;
            $display("FAIL en_glitch: got %0b want 1", fault_glitch);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (primed !== 1'b0 || fault_glitch !== 1'b0) begin
            n_bad++;
            $display("FAIL en_off: got pr=%0b g=%0b want 0/0", primed, fault_glitch);
        end
        n_cmp++;
        if (pos_out !== 32'd50 || turn_count !== 13'd0 || velocity !== (VEL ? 19'd50 : 19'd0)) begin
            n_bad++;
            $display("FAIL en_hold: got pos=%0d t=%0d v=%0d want 50/0/%0d", pos_out, turn_count, velocity, VEL ? 50 : 0);
        end
        base = pv_cnt;
        send(19'd9999, 1'b0);
        n_cmp++;
        if (pv_cnt - base !== 0 || pos_out !== 32'd50) begin
            n_bad++;
            $display("FAIL en_ignore: got pulses=%0d pos=%0d want 0/50", pv_cnt - base, pos_out);
        end
        enable = 1'b1;
        send(19'd700, 1'b0);
        n_cmp++;
        if (primed !== 1'b1 || pos_valid !== 1'b1 || pos_out !== 32'hFFFF_F704) begin
            n_bad++;
            $display("FAIL en_reprime: got pr=%0b v=%0b pos=%0h want 1/1/fffff704", primed, pos_valid, pos_out);
        end
        drive(19'd800, 1'b0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pos_valid !== 1'b1 || pos_out !== 32'hFFFF_F768 || primed !== 1'b0) begin
            n_bad++;
            $display("FAIL en_inflight: got v=%0b pos=%0h pr=%0b want 1/fffff768/0", pos_valid, pos_out, primed);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1'b1;
        send(19'd4000, 1'b0);
        send(19'd4100, 1'b0);
        n_cmp++;
        if (pos_out !== 32'd100) begin
            n_bad++;
            $display("FAIL rmid_pre: got %0d want 100", pos_out);
        end
        base = pv_cnt;
        drive(19'd4200, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pos_out !== 32'd0 || primed !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_async: got pos=%0d pr=%0b want 0/0", pos_out, primed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pv_cnt - base !== 0 || pos_out !== 32'd0 || turn_count !== 13'd0) begin
            n_bad++;
            $display("FAIL rmid_after: got pulses=%0d pos=%0d t=%0d want 0/0/0", pv_cnt - base, pos_out, turn_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1;
        sample_valid = 1'b1;
        sample_val = 19'd1000;
        @(negedge clk);
        sample_val = 19'd1010;
        @(negedge clk);
        sample_val = 19'd1030;
        @(negedge clk);
        sample_valid = 1'b0;
        n_cmp++;
        if (pos_valid !== 1'b1 || pos_out !== 32'd0) begin
            n_bad++;
            $display("FAIL b2b_0: got v=%0b pos=%0d want 1/0", pos_valid, pos_out);
        end
        @(negedge clk);
        n_cmp++;
        if (pos_valid !== 1'b1 || pos_out !== 32'd10 || period !== (VEL ? 24'd1 : 24'd0)) begin
            n_bad++;
            $display("FAIL b2b_1: got v=%0b pos=%0d p=%0d want 1/10/%0d", pos_valid, pos_out, period, VEL ? 1 : 0);
        end
        @(negedge clk);
        n_cmp++;
        if (pos_valid !== 1'b1 || pos_out !== 32'd30 || velocity !== (VEL ? 19'd20 : 19'd0)) begin
            n_bad++;
            $display("FAIL b2b_2: got v=%0b pos=%0d vel=%0d want 1/30/%0d", pos_valid, pos_out, velocity, VEL ? 20 : 0);
        end
        @(negedge clk);
        n_cmp++;
        if (pos_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: got %0b want 0", pos_valid);
        end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_wrap();
        test_glitch();
        test_stale();
        test_zero();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
